// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for the PISO transmitter.
// The slave side is the serializer; the master side is whoever feeds words
// in, paces the bits with enable and consumes the serial stream.
interface piso_serializer_if #(
  parameter int SIZE = 8
);
  logic [SIZE-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            enable;
  logic            out;
  logic            out_valid;
  logic            busy;
  logic            done;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output enable,
    input  out,
    input  out_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  enable,
    output out,
    output out_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word holding buffer so that
// consecutive words stream out with no idle bit between frames. One bit
// advances per cycle in which the shared enable strobe is high.
//
// state | meaning
// IDLE  | no frame on the line, out forced to 0
// SHIFT | a frame is being sent, out_valid/busy high
module piso_serializer #(
  parameter int SIZE      = 8,
  parameter bit SHIFT_DIR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  piso_serializer_if.slave s_if
);

  if (SIZE < 2) begin : g_size_check
    $error("piso_serializer: SIZE must be >= 2");
  end

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST_BIT = CW'(SIZE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] sreg_q, sreg_d;
  logic [CW-1:0]   bit_count_q, bit_count_d;
  logic [SIZE-1:0] hold_data_q, hold_data_d;
  logic            hold_full_q, hold_full_d;
  logic            done_q, done_d;
  logic            accept;
  logic [SIZE-1:0] sreg_shifted;

  // Handshake only looks at registered state, so in_ready never depends on inputs.
  assign accept       = s_if.in_valid && !hold_full_q;
  assign sreg_shifted = SHIFT_DIR ? (sreg_q << 1) : (sreg_q >> 1);

  // Next-state decode: bypass into the shifter when nothing is queued, otherwise park in hold.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_count_d = bit_count_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          sreg_d      = hold_data_q;
          hold_full_d = 1'b0;
          bit_count_d = '0;
          state_d     = SHIFT;
        end else if (accept) begin
          sreg_d      = s_if.in_data;
          bit_count_d = '0;
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        if (s_if.enable && (bit_count_q == LAST_BIT)) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            // Queued word takes over seamlessly; in_ready is low so nothing else lands.
            sreg_d      = hold_data_q;
            hold_full_d = 1'b0;
            bit_count_d = '0;
          end else if (accept) begin
            sreg_d      = s_if.in_data;
            bit_count_d = '0;
          end else begin
            sreg_d      = '0;
            bit_count_d = '0;
            state_d     = IDLE;
          end
        end else begin
          if (s_if.enable) begin
            sreg_d      = sreg_shifted;
            bit_count_d = bit_count_q + CW'(1);
          end
          if (accept) begin
            hold_data_d = s_if.in_data;
            hold_full_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any partial frame and the held word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bit_count_q <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_count_q <= bit_count_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      done_q      <= done_d;
    end
  end

  assign s_if.in_ready  = !hold_full_q;
  assign s_if.out_valid = (state_q == SHIFT);
  assign s_if.busy      = (state_q == SHIFT);
  assign s_if.done      = done_q;
  assign s_if.out       = (state_q == SHIFT) ?
                          (SHIFT_DIR ? sreg_q[SIZE-1] : sreg_q[0]) : 1'b0;

endmodule
